// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 3x3 keypad row scanner, frame debouncer and single-key code generator
// Optional build macro: KEYPAD_MULTIKEY_REJECT_EN
module keypad_scanner #(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       hwclk,
    input  logic       rst,
    output logic       keypad_r1,
    output logic       keypad_r2,
    output logic       keypad_r3,
    input  logic       keypad_c1,
    input  logic       keypad_c2,
    input  logic       keypad_c3,
    output logic [3:0] button,
    output logic       bstate,
    output logic       press,
    // `release` is a reserved word in SystemVerilog, hence the suffix
    output logic       release_pulse
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {ROW1, ROW2, ROW3} scan_state_t;
    typedef enum logic {IDLE, HELD} key_state_t;

    scan_state_t      scan_state, scan_next;
    logic [CNT_W-1:0] slot_cnt, slot_cnt_next;
    logic [2:0]       row_n, row_n_next;
    logic             slot_last;

    logic [2:0]       col_meta, col_sync;
    logic [8:0]       raw_frame, raw_next, prev_frame, deb_frame, deb_next;
    logic [STB_W-1:0] stable_cnt, stable_next;
    logic             frame_done;

    key_state_t       key_state, key_next;
    logic [3:0]       key_code, button_next;
    logic             accept, single_key, press_next, release_next;

    assign slot_last = (slot_cnt == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        scan_next     = scan_state;
        slot_cnt_next = slot_cnt + CNT_W'(1);
        if (slot_last) begin
            slot_cnt_next = '0;
            case (scan_state)
                ROW1:    scan_next = ROW2;
                ROW2:    scan_next = ROW3;
                default: scan_next = ROW1;
            endcase
        end
        case (scan_next)
            ROW1:    row_n_next = 3'b110;
            ROW2:    row_n_next = 3'b101;
            default: row_n_next = 3'b011;
        endcase
    end

    // Row drives are registered so they sit all-high through reset and track the state afterwards
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            scan_state <= ROW1;
            slot_cnt   <= '0;
            row_n      <= 3'b111;
        end else begin
            scan_state <= scan_next;
            slot_cnt   <= slot_cnt_next;
            row_n      <= row_n_next;
        end
    end

    assign keypad_r1 = row_n[0];
    assign keypad_r2 = row_n[1];
    assign keypad_r3 = row_n[2];

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            col_meta <= '0;
            col_sync <= '0;
        end else begin
            col_meta <= {keypad_c3, keypad_c2, keypad_c1};
            col_sync <= col_meta;
        end
    end

    // Frame bit index is 3*row + col, so key code is simply index + 1
    always_comb begin
        raw_next = raw_frame;
        if (slot_last) begin
            case (scan_state)
                ROW1:    raw_next[2:0] = ~col_sync;
                ROW2:    raw_next[5:3] = ~col_sync;
                default: raw_next[8:6] = ~col_sync;
            endcase
        end
        frame_done  = slot_last && (scan_state == ROW3);
        stable_next = stable_cnt;
        deb_next    = deb_frame;
        if (frame_done) begin
            if (raw_next == prev_frame) begin
                if (stable_cnt != STB_W'(DEBOUNCE_SCANS))
                    stable_next = stable_cnt + STB_W'(1);
            end else begin
                stable_next = STB_W'(1);
            end
            if (stable_next == STB_W'(DEBOUNCE_SCANS))
                deb_next = raw_next;
        end
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            raw_frame  <= '0;
            prev_frame <= '0;
            deb_frame  <= '0;
            stable_cnt <= '0;
        end else begin
            raw_frame  <= raw_next;
            stable_cnt <= stable_next;
            deb_frame  <= deb_next;
            if (frame_done)
                prev_frame <= raw_next;
        end
    end

    // Key FSM looks at the next debounced frame so outputs land one cycle after frame completion
    always_comb begin
        key_code = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (deb_next[i])
                key_code = 4'(i + 1);
        end
        single_key = (deb_next != 9'd0) && ((deb_next & (deb_next - 9'd1)) == 9'd0);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        accept = single_key;
`else
        accept = (deb_next != 9'd0);
`endif
    end

    always_comb begin
        key_next     = key_state;
        button_next  = button;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (key_state)
            IDLE: begin
                if (accept) begin
                    key_next    = HELD;
                    button_next = key_code;
                    press_next  = 1'b1;
                end
            end
            default: begin
                if (deb_next == 9'd0) begin
                    key_next     = IDLE;
                    release_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            key_state     <= IDLE;
            button        <= 4'd0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            key_state     <= key_next;
            button        <= button_next;
            press         <= press_next;
            release_pulse <= release_next;
        end
    end

    assign bstate = (key_state == HELD);

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Front-end stage of the digital lock that drives the 3x3 keypad rows, samples the columns, debounces the matrix and produces one clean key code per press. Its `button`/`bstate` outputs feed the length checker, validity checker and controller FSM directly. Downstream stages latch `button` on the falling edge of `bstate`, so the code is held stable through and after release.

## Interface

Parameters:
- `SCAN_DIV`, default 12000: clock cycles per row slot (1 ms at 12 MHz). Minimum 4.
- `DEBOUNCE_SCANS`, default 20: number of consecutive identical full-matrix frames required before the debounced state changes. Minimum 2.

Ports:
- `hwclk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `keypad_r1`, `keypad_r2`, `keypad_r3` output 1 each: row drives, active-low, exactly one low at a time outside reset.
- `keypad_c1`, `keypad_c2`, `keypad_c3` input 1 each: column sense, asynchronous, pulled up externally; low means pressed.
- `button` output 4: code of the last accepted key, 1..9, or 0 after reset.
- `bstate` output 1: high while the accepted key is held (debounced).
- `press` output 1: one-cycle pulse when a key is accepted.
- `release` output 1: one-cycle pulse when `bstate` falls.

## Operation

- Key code = 3*row + col + 1, with row and col each in 0..2 (r1/c1 = 0). Row 0 gives 1,2,3; row 2 gives 7,8,9.
- Column inputs pass through a 2-flop synchronizer per column before use.
- The scan FSM has states ROW1, ROW2 and ROW3, cycling in that order.
  - Each state lasts `SCAN_DIV` cycles and drives its own row low and the other two rows high.
  - The slot counter wraps from `SCAN_DIV`-1 to 0 and advances the state; ROW3 wraps to ROW1.
- Sampling happens on the last cycle of each slot (counter = `SCAN_DIV`-1). The inverted synchronized columns are written into that row's 3 bits of a 9-bit raw frame.
- A frame is complete at the ROW3 sample cycle.
- Debounce on each frame completion:
  - If the raw frame equals the previous frame, the stable counter increments, saturating at `DEBOUNCE_SCANS`.
  - Otherwise the stable counter is set to 1.
  - When the counter reaches `DEBOUNCE_SCANS`, the raw frame becomes the debounced frame.
- The key FSM has two states, IDLE and HELD.
  - IDLE to HELD: the debounced frame is non-zero and a key is selected (see Configuration). Load `button` with the key code, set `bstate`=1 and pulse `press`.
  - HELD to IDLE: the debounced frame is all-zero. Clear `bstate` and pulse `release`. `button` keeps its value.
  - While HELD, adding or removing other keys has no effect. Release is declared only when all keys are up.
- `button` changes only on an IDLE-to-HELD transition.

## Timing

- Reset values: `keypad_r1`/`keypad_r2`/`keypad_r3` = 1/1/1, `button`=0, `bstate`=0, `press`=0, `release`=0.
  - Internally: FSM in ROW1 with slot counter 0, synchronizers 0, frames 0, stable counter 0, key FSM in IDLE.
- First cycle after reset deasserts: `keypad_r1`=0.
- Full frame period: 3*`SCAN_DIV` cycles.
- Press latency: `press`, `bstate` and `button` update on the cycle after the frame completion on which the stable count reaches `DEBOUNCE_SCANS`.
  - That is (`DEBOUNCE_SCANS`-1)*3*`SCAN_DIV` + 1 cycles after completion of the first frame containing the key.
- Release latency is the same, measured from the first all-zero frame.
- `press` and `release` are never both high in the same cycle. Each is high for exactly one cycle per event.
- Column changes need at least 2 cycles to reach the sample point. Shorter settling within a slot is not required.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronously). `bstate` falls with no `release` pulse.
  - A key still held after reset is re-debounced and produces a fresh `press`.
- A bounce at any time resets the stable counter to 1, so no partial debounce credit survives it.

## Configuration

- `KEYPAD_MULTIKEY_REJECT_EN` defined:
  - In IDLE, a debounced frame with two or more set bits is ignored: no `press`, and the FSM stays in IDLE until a frame with exactly one set bit is debounced.
- Not defined:
  - In IDLE, any non-zero debounced frame is accepted, and the lowest key code present is selected.

## Test plan

Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3, giving a 12-cycle frame.

- Reset, then release it → all outputs at reset values. Then `keypad_r1` low for 4 cycles, `keypad_r2` low for 4, `keypad_r3` low for 4, repeating.
- Model key 5 (c2 low while r2 low), held for 6 frames, then released → one `press` pulse, `button`=5 and `bstate`=1 from 25 cycles after the first full frame. After release: `bstate`=0, one `release` pulse, `button` stays 5.
- Key 2 pattern present for 2 frames, absent 1 frame, present 2 frames → no `press`, `button`=0, `bstate`=0.
- Keys 1 and 9 pressed together for 5 frames → with the macro defined, no `press`. Without it, `press` fires with `button`=1.
- Key 3 held and accepted; then key 7 added; then key 3 released with key 7 still held; then all released → `button` stays 3, no second `press`, one `release` only after all keys are up.
- Key 4 held with `bstate`=1, then `rst` pulsed for 1 cycle → `bstate` drops in the reset cycle with no `release`. A fresh `press` with `button`=4 follows 25 cycles after the first complete post-reset frame.
